// File: rtl/fft_pkg.sv
// Shared FFT butterfly types, constants and saturation helpers.
// Used by the butterfly coprocessor, the ALU result mux and FFT test code.
package fft_pkg;

    localparam int HALF_W  = 16;
    localparam int TW_FRAC = 14;
    localparam int CPLX_W  = 2 * HALF_W;
    localparam int ACC_W   = 40;

    localparam logic [HALF_W-1:0] TW_ONE = 16'h4000;

    typedef struct packed {
        logic signed [HALF_W-1:0] re;
        logic signed [HALF_W-1:0] im;
    } cplx_t;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t SAT_MAX = acc_t'((1 << (HALF_W - 1)) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(1 << (HALF_W - 1)));
    localparam acc_t RND     = acc_t'(1 << (TW_FRAC - 1));

    function automatic logic signed [CPLX_W-1:0] smul(
        input logic signed [HALF_W-1:0] x,
        input logic signed [HALF_W-1:0] y
    );
        logic signed [CPLX_W-1:0] xe;
        logic signed [CPLX_W-1:0] ye;
        xe = CPLX_W'(x);
        ye = CPLX_W'(y);
        return xe * ye;
    endfunction

    function automatic logic sat_ovf(input acc_t x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    function automatic logic signed [HALF_W-1:0] sat_hw(input acc_t x);
        if (x > SAT_MAX) return SAT_MAX[HALF_W-1:0];
        if (x < SAT_MIN) return SAT_MIN[HALF_W-1:0];
        return x[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/fft_butterfly_resp_if.sv
// Request/response channel between the EX stage and the butterfly.
// slave: the butterfly; master: the issuing core side.
interface fft_butterfly_resp_if #(parameter int TAG_W = 5);
    import fft_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [CPLX_W-1:0] req_a;
    logic [CPLX_W-1:0] req_b;
    logic [CPLX_W-1:0] req_w;
    logic              req_scale;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic              resp_ready;
    logic [CPLX_W-1:0] resp_a;
    logic [CPLX_W-1:0] resp_b;
    logic [TAG_W-1:0]  resp_tag;

    modport slave (
        input  req_valid, req_a, req_b, req_w,
        input  req_scale, req_tag, resp_ready,
        output req_ready, resp_valid,
        output resp_a, resp_b, resp_tag
    );

    modport master (
        output req_valid, req_a, req_b, req_w,
        output req_scale, req_tag, resp_ready,
        input  req_ready, resp_valid,
        input  resp_a, resp_b, resp_tag
    );

endinterface

// File: rtl/fft_butterfly_resp_cmul.sv
// cmul_round: S1 (four products) and S2 (round, shift, saturate W*B).
// Ports: en/flush control, S1 inputs, S2 outputs with sat bit, s12_busy.
module cmul_round
    import fft_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  cplx_t            in_a,
    input  cplx_t            in_b,
    input  cplx_t            in_w,
    input  logic             in_scale,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output cplx_t            out_a,
    output cplx_t            out_p,
    output logic             out_scale,
    output logic             out_sat,
    output logic [TAG_W-1:0] out_tag,
    output logic             s12_busy
);

    logic              v1_q, v1_d, v2_q, v2_d;
    cplx_t             a1_q, a1_d, a2_q, a2_d;
    cplx_t             p2_q, p2_d;
    logic              sc1_q, sc1_d, sc2_q, sc2_d;
    logic              sat2_q, sat2_d;
    logic [TAG_W-1:0]  tag1_q, tag1_d, tag2_q, tag2_d;
    logic signed [CPLX_W-1:0] m_rr_q, m_rr_d, m_ii_q, m_ii_d;
    logic signed [CPLX_W-1:0] m_ri_q, m_ri_d, m_ir_q, m_ir_d;
    acc_t              re_r, im_r;

    // Round half up, then arithmetic shift back to integer scale.
    always_comb begin
        re_r = (acc_t'(m_rr_q) - acc_t'(m_ii_q) + RND) >>> TW_FRAC;
        im_r = (acc_t'(m_ri_q) + acc_t'(m_ir_q) + RND) >>> TW_FRAC;
    end

    always_comb begin
        v1_d   = v1_q;
        a1_d   = a1_q;
        sc1_d  = sc1_q;
        tag1_d = tag1_q;
        m_rr_d = m_rr_q;
        m_ii_d = m_ii_q;
        m_ri_d = m_ri_q;
        m_ir_d = m_ir_q;
        v2_d   = v2_q;
        a2_d   = a2_q;
        sc2_d  = sc2_q;
        tag2_d = tag2_q;
        p2_d   = p2_q;
        sat2_d = sat2_q;
        if (en) begin
            v1_d    = in_valid;
            a1_d    = in_a;
            sc1_d   = in_scale;
            tag1_d  = in_tag;
            m_rr_d  = smul(in_b.re, in_w.re);
            m_ii_d  = smul(in_b.im, in_w.im);
            m_ri_d  = smul(in_b.re, in_w.im);
            m_ir_d  = smul(in_b.im, in_w.re);
            v2_d    = v1_q;
            a2_d    = a1_q;
            sc2_d   = sc1_q;
            tag2_d  = tag1_q;
            p2_d.re = sat_hw(re_r);
            p2_d.im = sat_hw(im_r);
            sat2_d  = sat_ovf(re_r) | sat_ovf(im_r);
        end
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            sc1_q  <= 1'b0;
            tag1_q <= '0;
            m_rr_q <= '0;
            m_ii_q <= '0;
            m_ri_q <= '0;
            m_ir_q <= '0;
            v2_q   <= 1'b0;
            a2_q   <= '0;
            sc2_q  <= 1'b0;
            tag2_q <= '0;
            p2_q   <= '0;
            sat2_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            sc1_q  <= sc1_d;
            tag1_q <= tag1_d;
            m_rr_q <= m_rr_d;
            m_ii_q <= m_ii_d;
            m_ri_q <= m_ri_d;
            m_ir_q <= m_ir_d;
            v2_q   <= v2_d;
            a2_q   <= a2_d;
            sc2_q  <= sc2_d;
            tag2_q <= tag2_d;
            p2_q   <= p2_d;
            sat2_q <= sat2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_a     = a2_q;
    assign out_p     = p2_q;
    assign out_scale = sc2_q;
    assign out_sat   = sat2_q;
    assign out_tag   = tag2_q;
    assign s12_busy  = v1_q | v2_q;

endmodule

// File: rtl/fft_butterfly_resp.sv
// Radix-2 DIT butterfly responder: A' = A + W*B, B' = A - W*B.
// Ports: clk, rst (sync low), flush, bus (slave), busy, sat_flag/sat_clr, op_count.
module fft_butterfly_resp
    import fft_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    fft_butterfly_resp_if.slave  bus,
    output logic                 busy,
    output logic                 sat_flag,
    input  logic                 sat_clr,
    output logic [15:0]          op_count
);

    logic             en, accept, deliver, s12_busy;
    logic             s2_valid, s2_scale, s2_sat;
    cplx_t            s2_a, s2_p;
    logic [TAG_W-1:0] s2_tag;

    logic             v3_q, v3_d, sat3_q, sat3_d;
    cplx_t            ra_q, ra_d, rb_q, rb_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             satf_q, satf_d;
    acc_t             s_re, s_im, d_re, d_im;

    // A held response freezes the whole pipe.
    assign en            = !(v3_q && !bus.resp_ready);
    assign bus.req_ready = en && !flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign deliver       = v3_q && bus.resp_ready;

    cmul_round #(.TAG_W(TAG_W)) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (accept),
        .in_a      (bus.req_a),
        .in_b      (bus.req_b),
        .in_w      (bus.req_w),
        .in_scale  (bus.req_scale),
        .in_tag    (bus.req_tag),
        .out_valid (s2_valid),
        .out_a     (s2_a),
        .out_p     (s2_p),
        .out_scale (s2_scale),
        .out_sat   (s2_sat),
        .out_tag   (s2_tag),
        .s12_busy  (s12_busy)
    );

    always_comb begin
        s_re = acc_t'($signed(s2_a.re)) + acc_t'($signed(s2_p.re));
        s_im = acc_t'($signed(s2_a.im)) + acc_t'($signed(s2_p.im));
        d_re = acc_t'($signed(s2_a.re)) - acc_t'($signed(s2_p.re));
        d_im = acc_t'($signed(s2_a.im)) - acc_t'($signed(s2_p.im));
        if (s2_scale) begin
            s_re = s_re >>> 1;
            s_im = s_im >>> 1;
            d_re = d_re >>> 1;
            d_im = d_im >>> 1;
        end
    end

    always_comb begin
        v3_d   = v3_q;
        ra_d   = ra_q;
        rb_d   = rb_q;
        tag3_d = tag3_q;
        sat3_d = sat3_q;
        if (en) begin
            v3_d    = s2_valid;
            ra_d.re = sat_hw(s_re);
            ra_d.im = sat_hw(s_im);
            rb_d.re = sat_hw(d_re);
            rb_d.im = sat_hw(d_im);
            tag3_d  = s2_tag;
            sat3_d  = s2_sat | sat_ovf(s_re) | sat_ovf(s_im)
                    | sat_ovf(d_re) | sat_ovf(d_im);
        end
        if (flush) v3_d = 1'b0;
    end

    // A saturated delivery wins over a same-cycle clear.
    always_comb begin
        cnt_d  = deliver ? cnt_q + 16'd1 : cnt_q;
        satf_d = satf_q;
        if (sat_clr) satf_d = 1'b0;
        if (deliver && sat3_q) satf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v3_q   <= 1'b0;
            ra_q   <= '0;
            rb_q   <= '0;
            tag3_q <= '0;
            sat3_q <= 1'b0;
            cnt_q  <= '0;
            satf_q <= 1'b0;
        end else begin
            v3_q   <= v3_d;
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            tag3_q <= tag3_d;
            sat3_q <= sat3_d;
            cnt_q  <= cnt_d;
            satf_q <= satf_d;
        end
    end

    assign bus.resp_valid = v3_q;
    assign bus.resp_a     = ra_q;
    assign bus.resp_b     = rb_q;
    assign bus.resp_tag   = tag3_q;
    assign busy           = s12_busy | v3_q;
    assign sat_flag       = satf_q;
    assign op_count       = cnt_q;

endmodule

// File: tb/tb_fft_butterfly_resp.sv
// Directed bench for fft_butterfly_resp.
// Drives the request channel and checks responses and status outputs.
module tb_fft_butterfly_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        sat_clr;
    logic        busy;
    logic        sat_flag;
    logic [15:0] op_count;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] cnt_exp;

    localparam logic [31:0] W_ONE = 32'h4000_0000;

    fft_butterfly_resp_if #(.TAG_W(5)) bus ();

    fft_butterfly_resp #(.TAG_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .busy     (busy),
        .sat_flag (sat_flag),
        .sat_clr  (sat_clr),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = 16'(re);
        i = 16'(im);
        return {r, i};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] w, input logic sc,
                         input logic [4:0] tg);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_w     = w;
        bus.req_scale = sc;
        bus.req_tag   = tg;
    endtask

    task automatic run_one(input string nm, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] w,
                           input logic sc, input logic [4:0] tg,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input logic clr, input logic esat);
        bus.resp_ready = 1'b1;
        drive(a, b, w, sc, tg);
        #1;
        chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 1'b0;
        step();
        chk({nm, "_early_valid"}, 64'(bus.resp_valid), 64'd0);
        step();
        chk({nm, "_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({nm, "_a"}, 64'(bus.resp_a), 64'(ea));
        chk({nm, "_b"}, 64'(bus.resp_b), 64'(eb));
        chk({nm, "_tag"}, 64'(bus.resp_tag), 64'(tg));
        sat_clr = clr;
        step();
        sat_clr = 1'b0;
        cnt_exp = cnt_exp + 16'd1;
        chk({nm, "_count"}, 64'(op_count), 64'(cnt_exp));
        chk({nm, "_sat"}, 64'(sat_flag), 64'(esat));
        chk({nm, "_after_valid"}, 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic fill3(input logic [4:0] base);
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(pk(i, 0), pk(1, 1), W_ONE, 1'b0, base + 5'(i));
            #1;
            chk("fill_req_ready", 64'(bus.req_ready), 64'd1);
            step();
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int          nxt;
        int          got;
        int          seen;
        logic        acc;
        logic        stalled;
        logic [31:0] ha;
        logic [31:0] hb;
        logic [4:0]  ht;

        rst = 1'b0;
        flush = 1'b0;
        sat_clr = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_w = '0;
        bus.req_scale = 1'b0;
        bus.req_tag = '0;
        bus.resp_ready = 1'b1;
        cnt_exp = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(op_count), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_a", 64'(bus.resp_a), 64'd0);

        run_one("ident", pk(100, 50), pk(20, -10), W_ONE, 1'b0, 5'd3,
                pk(120, 40), pk(80, 60), 1'b0, 1'b0);
        run_one("scale", pk(100, 50), pk(20, -10), W_ONE, 1'b1, 5'd4,
                pk(60, 20), pk(40, 30), 1'b0, 1'b0);
        run_one("negj", pk(100, 50), pk(20, -10), pk(0, -16384), 1'b0,
                5'd5, pk(90, 30), pk(110, 70), 1'b0, 1'b0);
        run_one("round", pk(0, 0), pk(1, 0), pk(8192, 0), 1'b0, 5'd6,
                pk(1, 0), pk(-1, 0), 1'b0, 1'b0);
        run_one("sat", pk(32767, 0), pk(32767, 0), W_ONE, 1'b0, 5'd7,
                pk(32767, 0), pk(0, 0), 1'b0, 1'b1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_clr", 64'(sat_flag), 64'd0);
        run_one("sat_vs_clr", pk(32767, 0), pk(32767, 0), W_ONE, 1'b0,
                5'd8, pk(32767, 0), pk(0, 0), 1'b1, 1'b1);
        run_one("clr_nosat", pk(1, 1), pk(0, 0), W_ONE, 1'b0, 5'd9,
                pk(1, 1), pk(1, 1), 1'b1, 1'b0);
        run_one("sat_neg", pk(-32768, 0), pk(-32768, 0), W_ONE, 1'b0,
                5'd10, pk(-32768, 0), pk(0, 0), 1'b0, 1'b1);

        nxt = 0;
        got = 0;
        stalled = 1'b0;
        ha = '0;
        hb = '0;
        ht = '0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            bus.resp_ready = 1'($urandom_range(0, 1));
            if (nxt < 8)
                drive(pk(10 * nxt, nxt), pk(nxt, 0), W_ONE, 1'b0, 5'(nxt));
            else
                bus.req_valid = 1'b0;
            #1;
            if (stalled) begin
                chk("bp_hold_a", 64'(bus.resp_a), 64'(ha));
                chk("bp_hold_b", 64'(bus.resp_b), 64'(hb));
                chk("bp_hold_tag", 64'(bus.resp_tag), 64'(ht));
            end
            if (bus.resp_valid && bus.resp_ready) begin
                chk("bp_tag", 64'(bus.resp_tag), 64'(got));
                chk("bp_a", 64'(bus.resp_a), 64'(pk(11 * got, got)));
                chk("bp_b", 64'(bus.resp_b), 64'(pk(9 * got, got)));
                got++;
            end
            acc = bus.req_valid && bus.req_ready;
            stalled = bus.resp_valid && !bus.resp_ready;
            ha = bus.resp_a;
            hb = bus.resp_b;
            ht = bus.resp_tag;
            step();
            if (acc) nxt++;
        end
        bus.req_valid = 1'b0;
        cnt_exp = cnt_exp + 16'd8;
        chk("bp_delivered", 64'(got), 64'd8);
        chk("bp_count", 64'(op_count), 64'(cnt_exp));

        fill3(5'd20);
        chk("fl_busy_before", 64'(busy), 64'd1);
        chk("fl_valid_before", 64'(bus.resp_valid), 64'd1);
        flush = 1'b1;
        drive(pk(5, 5), pk(1, 1), W_ONE, 1'b0, 5'd23);
        #1;
        chk("fl_req_ready", 64'(bus.req_ready), 64'd0);
        step();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("fl_busy_after", 64'(busy), 64'd0);
        bus.resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid) seen++;
            step();
        end
        chk("fl_none_delivered", 64'(seen), 64'd0);
        chk("fl_count", 64'(op_count), 64'(cnt_exp));
        flush = 1'b1;
        drive(pk(5, 5), pk(1, 1), W_ONE, 1'b0, 5'd24);
        #1;
        chk("fl_empty_req_ready", 64'(bus.req_ready), 64'd0);
        step();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("fl_empty_busy", 64'(busy), 64'd0);

        fill3(5'd25);
        chk("mr_sat_before", 64'(sat_flag), 64'd1);
        chk("mr_valid_before", 64'(bus.resp_valid), 64'd1);
        rst = 1'b0;
        step();
        chk("mr_valid", 64'(bus.resp_valid), 64'd0);
        chk("mr_a", 64'(bus.resp_a), 64'd0);
        chk("mr_b", 64'(bus.resp_b), 64'd0);
        chk("mr_tag", 64'(bus.resp_tag), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_sat", 64'(sat_flag), 64'd0);
        chk("mr_count", 64'(op_count), 64'd0);
        rst = 1'b1;
        bus.resp_ready = 1'b1;
        step();
        chk("mr_req_ready", 64'(bus.req_ready), 64'd1);
        cnt_exp = '0;

        drive(pk(1, 0), pk(1, 0), W_ONE, 1'b0, 5'd1);
        repeat (65535) step();
        bus.req_valid = 1'b0;
        repeat (4) step();
        chk("wrap_pre", 64'(op_count), 64'hFFFF);
        cnt_exp = 16'hFFFF;
        run_one("wrap", pk(1, 0), pk(1, 0), W_ONE, 1'b0, 5'd2,
                pk(2, 0), pk(0, 0), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
